// File: rtl/apb_pkg.sv
// Shared APB master-side definitions: FSM state encoding and default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int ADDR_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] grant_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [NUM_REQ-1:0]   grant_rot;
    logic [IDX_W-1:0]     offset_acc [NUM_REQ+1];
    logic [IDX_W:0]       idx_sum;

    // Rotate so rr_ptr sits at bit 0, pick the lowest set bit, then rotate back.
    assign req_dbl    = {req, req};
    assign req_rot    = NUM_REQ'(req_dbl >> rr_ptr);
    assign offset_acc[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_pri
            if (gi == 0) begin : g_first
                assign grant_rot[gi] = req_rot[gi];
            end else begin : g_rest
                assign grant_rot[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
            end
            assign offset_acc[gi+1] = offset_acc[gi] | (grant_rot[gi] ? IDX_W'(gi) : '0);
        end
    endgenerate

    assign grant_dbl   = {{NUM_REQ{1'b0}}, grant_rot} << rr_ptr;
    assign grant       = grant_dbl[NUM_REQ-1:0] | grant_dbl[2*NUM_REQ-1:NUM_REQ];
    assign grant_valid = |req;

    assign idx_sum   = {1'b0, rr_ptr} + {1'b0, offset_acc[NUM_REQ]};
    assign grant_idx = (idx_sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(idx_sum - (IDX_W+1)'(NUM_REQ))
                                                        : IDX_W'(idx_sum);

endmodule

// File: rtl/apb_ram_arbiter.sv
// Shares one APB slave between NUM_REQ req/done clients with round-robin arbitration
// and an ACCESS-phase timeout that aborts a transfer with err=1.
module apb_ram_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [IDX_W-1:0]     win_reg, win_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic                 write_reg, write_next;
    logic [DATA_W-1:0]    wdata_reg, wdata_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [NUM_REQ-1:0]   done_reg, done_next;
    logic                 err_reg, err_next;
    logic [DATA_W-1:0]    rdata_reg, rdata_next;

    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic [IDX_W-1:0]     win_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // One-hot AND-OR mux of the winning requester's command fields.
    logic [ADDR_W-1:0] addr_acc  [NUM_REQ+1];
    logic [DATA_W-1:0] wdata_acc [NUM_REQ+1];
    logic [NUM_REQ:0]  write_acc;

    assign addr_acc[0]  = '0;
    assign wdata_acc[0] = '0;
    assign write_acc[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
            assign addr_acc[gi+1]  = addr_acc[gi]  | (req_addr[gi*ADDR_W +: ADDR_W]  & {ADDR_W{grant[gi]}});
            assign wdata_acc[gi+1] = wdata_acc[gi] | (req_wdata[gi*DATA_W +: DATA_W] & {DATA_W{grant[gi]}});
            assign write_acc[gi+1] = write_acc[gi] | (req_write[gi] & grant[gi]);
        end
    endgenerate

    assign win_inc = (win_reg == IDX_W'(NUM_REQ - 1)) ? '0 : win_reg + 1'b1;

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        win_next    = win_reg;
        addr_next   = addr_reg;
        write_next  = write_reg;
        wdata_next  = wdata_reg;
        cnt_next    = cnt_reg;
        done_next   = '0;
        err_next    = 1'b0;
        rdata_next  = rdata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    win_next   = grant_idx;
                    addr_next  = addr_acc[NUM_REQ];
                    write_next = write_acc[NUM_REQ];
                    wdata_next = wdata_acc[NUM_REQ];
                    cnt_next   = '0;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    done_next   = NUM_REQ'(1) << win_reg;
                    rdata_next  = write_reg ? rdata_reg : prdata;
                    rr_ptr_next = win_inc;
                    state_next  = IDLE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    done_next   = NUM_REQ'(1) << win_reg;
                    err_next    = 1'b1;
                    rdata_next  = '0;
                    rr_ptr_next = win_inc;
                    state_next  = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            win_reg    <= '0;
            addr_reg   <= '0;
            write_reg  <= 1'b0;
            wdata_reg  <= '0;
            cnt_reg    <= '0;
            done_reg   <= '0;
            err_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            win_reg    <= win_next;
            addr_reg   <= addr_next;
            write_reg  <= write_next;
            wdata_reg  <= wdata_next;
            cnt_reg    <= cnt_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
            rdata_reg  <= rdata_next;
        end
    end

    assign psel    = (state_reg != IDLE);
    assign penable = (state_reg == ACCESS);
    assign pwrite  = psel ? write_reg : 1'b0;
    assign paddr   = psel ? addr_reg  : '0;
    assign pwdata  = psel ? wdata_reg : '0;
    assign done    = done_reg;
    assign err     = err_reg;
    assign rdata   = rdata_reg;

endmodule

// File: tb/tb_apb_ram_arbiter.sv
// Bench for apb_ram_arbiter: APB slave stub with random wait states, transaction-level
// model of arbitration/timeout checked every cycle, plus directed scenarios.
module tb_apb_ram_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic preset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    done;
    logic            err;
    logic [DW-1:0]   rdata;
    logic            psel, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pready = 1'b0;
    logic [DW-1:0]   prdata = '0;

    always #5 clk = ~clk;

    apb_ram_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .pclk      (clk),
        .preset    (preset),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pready    (pready),
        .prdata    (prdata)
    );

    logic [DW-1:0] slave_mem [0:255];
    logic [DW-1:0] model_mem [0:255];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pready_pct = 100;

    // Model: one outstanding transfer described by its age (0 = setup cycle,
    // k >= 1 = k-th access cycle); done/err/rdata are what the bus shows now.
    bit            m_busy;
    int            m_age;
    int            m_win;
    int            m_ptr;
    logic [AW-1:0] m_addr;
    bit            m_write;
    logic [DW-1:0] m_wdata;
    logic [N-1:0]  e_done;
    bit            e_err;
    logic [DW-1:0] e_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_age = 0; m_win = 0; m_ptr = 0;
        m_addr = '0; m_write = 0; m_wdata = '0;
        e_done = '0; e_err = 0; e_rdata = '0;
    endtask

    task automatic check_all();
        chk("psel",    32'(psel),    32'(m_busy));
        chk("penable", 32'(penable), 32'(m_busy && m_age >= 1));
        chk("pwrite",  32'(pwrite),  32'(m_busy ? m_write : 1'b0));
        chk("paddr",   32'(paddr),   32'(m_busy ? m_addr : '0));
        chk("pwdata",  32'(pwdata),  32'(m_busy ? m_wdata : '0));
        chk("done",    32'(done),    32'(e_done));
        chk("err",     32'(err),     32'(e_err));
        chk("rdata",   32'(rdata),   32'(e_rdata));
    endtask

    // What the next clock edge must produce, from the current inputs.
    task automatic model_step();
        logic [N-1:0] nd;
        bit ne;
        bit found;
        bit finish;
        nd = '0; ne = 0; finish = 0;
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    m_win = (m_ptr + k) % N;
                    found = 1;
                end
            end
            if (found) begin
                m_addr  = req_addr[m_win*AW +: AW];
                m_write = req_write[m_win];
                m_wdata = req_wdata[m_win*DW +: DW];
                m_busy  = 1;
                m_age   = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (pready) begin
            if (m_write) model_mem[m_addr[7:0]] = m_wdata;
            else         e_rdata = model_mem[m_addr[7:0]];
            finish = 1;
        end else if (m_age == TO) begin
            ne = 1;
            e_rdata = '0;
            finish = 1;
        end else begin
            m_age++;
        end
        if (finish) begin
            nd[m_win] = 1'b1;
            m_ptr  = (m_win + 1) % N;
            m_busy = 0;
        end
        e_done = nd;
        e_err  = ne;
    endtask

    // One cycle: respond as slave, compare, predict the edge, advance.
    task automatic tick();
        if (psel && penable) pready = ($urandom_range(99) < pready_pct);
        else                 pready = 1'($urandom_range(1));
        prdata = slave_mem[paddr[7:0]];
        #1;
        check_all();
        if (preset) model_step();
        else        model_reset();
        if (preset && psel && penable && pready && pwrite) slave_mem[paddr[7:0]] = pwdata;
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int idx);
        idx = -1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (e_done != '0) begin
                for (int i = 0; i < N; i++) if (e_done[i]) idx = i;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_done cycle=%0d got=no_done expected=done_within_%0d", cyc, budget);
    endtask

    task automatic wait_penable(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (penable) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_penable cycle=%0d got=penable_low expected=penable_within_%0d", cyc, budget);
    endtask

    task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i] = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i] = 1'b1;
    endtask

    int idx;
    int c0;
    int exp_seq [4] = '{0, 1, 0, 1};

    initial begin
        for (int a = 0; a < 256; a++) begin
            slave_mem[a] = 16'($urandom);
            model_mem[a] = slave_mem[a];
        end
        slave_mem[8'h10] = 16'hBEEF;
        model_mem[8'h10] = 16'hBEEF;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick();
        chk("rst_psel", 32'(psel), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rdata", 32'(rdata), 0);
        preset = 1'b1;
        tick();

        // Single read with zero-wait slave: psel +1, penable +2, done +3.
        pready_pct = 100;
        set_req(0, 0, 16'h0010, 16'h0000);
        tick();
        chk("t1_psel_p1", 32'(psel), 1);
        chk("t1_penable_p1", 32'(penable), 0);
        tick();
        chk("t1_penable_p2", 32'(penable), 1);
        tick();
        chk("t1_done_p3", 32'(done), 32'h1);
        chk("t1_rdata", 32'(rdata), 32'hBEEF);
        chk("t1_err", 32'(err), 0);
        req = '0;
        tick(); tick();

        // Requester 1: write then read back.
        pready_pct = 60;
        set_req(1, 1, 16'h0020, 16'h1234);
        wait_done(200, idx);
        chk("t2_wdone", 32'(done), 32'h2);
        req = '0;
        tick();
        set_req(1, 0, 16'h0020, 16'h0000);
        wait_done(200, idx);
        chk("t2_rdata", 32'(rdata), 32'h1234);
        req = '0;
        tick();

        // Both requesting continuously: strict alternation, one IDLE cycle between.
        pready_pct = 100;
        set_req(0, 0, 16'h0001, 16'h0);
        set_req(1, 0, 16'h0002, 16'h0);
        for (int t = 0; t < 4; t++) begin
            wait_done(50, idx);
            chk("t3_grant", 32'(idx), 32'(exp_seq[t]));
            if (t < 3) begin
                tick();
                chk("t3_gap_setup", 32'(psel), 1);
            end
        end
        req = '0;
        tick();

        // Timeout: slave never ready; done 16 cycles after penable rises.
        pready_pct = 0;
        set_req(0, 0, 16'h0003, 16'h0);
        set_req(1, 0, 16'h0004, 16'h0);
        wait_penable(10);
        c0 = cyc;
        wait_done(40, idx);
        chk("t4_latency", 32'(cyc - c0), 32'(TO));
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_err", 32'(err), 1);
        chk("t4_rdata", 32'(rdata), 0);
        pready_pct = 100;
        wait_done(20, idx);
        chk("t4_next", 32'(done), 32'h2);
        chk("t4_next_err", 32'(err), 0);
        req = '0;
        tick();

        // Address change during ACCESS is ignored.
        pready_pct = 30;
        set_req(0, 0, 16'h0030, 16'h0);
        wait_penable(10);
        req_addr[0 +: AW] = 16'h0040;
        req_write[0] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (psel) chk("t5_paddr", 32'(paddr), 32'h0030);
            if (e_done != '0) break;
            tick();
        end
        req = '0;
        tick();

        // Async reset during ACCESS; afterwards rr_ptr restarts at 0.
        pready_pct = 0;
        set_req(1, 0, 16'h0005, 16'h0);
        wait_penable(10);
        tick(); tick();
        preset = 1'b0;
        model_reset();
        #1;
        chk("t6_psel", 32'(psel), 0);
        chk("t6_penable", 32'(penable), 0);
        chk("t6_done", 32'(done), 0);
        set_req(0, 0, 16'h0006, 16'h0);
        tick(); tick();
        preset = 1'b1;
        pready_pct = 100;
        tick();
        chk("t6_restart_setup", 32'(psel), 1);
        wait_done(20, idx);
        chk("t6_first_grant", 32'(done), 32'h1);
        req = '0;
        tick();

        // Randomized traffic across a range of slave wait behaviour.
        foreach (exp_seq[s]) begin end
        for (int chunk = 0; chunk < 6; chunk++) begin
            case (chunk)
                0: pready_pct = 100;
                1: pready_pct = 70;
                2: pready_pct = 40;
                3: pready_pct = 10;
                4: pready_pct = 3;
                default: pready_pct = 80;
            endcase
            for (int c = 0; c < 500; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i]) begin
                        if ($urandom_range(3) == 0)
                            set_req(i, 1'($urandom_range(1)), 16'($urandom_range(63)), 16'($urandom));
                    end else if ($urandom_range(7) == 0) begin
                        req_addr[i*AW +: AW]  = 16'($urandom_range(63));
                        req_wdata[i*DW +: DW] = 16'($urandom);
                        req_write[i] = 1'($urandom_range(1));
                    end
                end
                if (m_busy && $urandom_range(15) == 0) req[m_win] = 1'b0;
                tick();
                for (int i = 0; i < N; i++)
                    if (e_done[i] && $urandom_range(2) != 0) req[i] = 1'b0;
            end
        end
        req = '0;
        for (int k = 0; k < 40; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
